// File: rtl/maj_net_pkg.sv
// Shared constants, cfg_data field layout and FSM state type for the MAJ network sequencer.
package maj_net_pkg;

    localparam int unsigned NUM_GATES = 8;
    localparam int unsigned N_IN      = 7;
    localparam int unsigned N_PAT     = 128;

    // cfg_data = {inv[2:0], sel2[3:0], sel1[3:0], sel0[3:0]}
    localparam int unsigned SEL_W    = 4;
    localparam int unsigned INV_W    = 3;
    localparam int unsigned CFG_W    = INV_W + 3 * SEL_W;
    localparam int unsigned SEL0_OFS = 0;
    localparam int unsigned SEL1_OFS = 4;
    localparam int unsigned SEL2_OFS = 8;
    localparam int unsigned INV_OFS  = 12;

    // Operand select codes
    localparam logic [SEL_W-1:0] SEL_X0   = 4'd0;
    localparam logic [SEL_W-1:0] SEL_X1   = 4'd1;
    localparam logic [SEL_W-1:0] SEL_X2   = 4'd2;
    localparam logic [SEL_W-1:0] SEL_X3   = 4'd3;
    localparam logic [SEL_W-1:0] SEL_X4   = 4'd4;
    localparam logic [SEL_W-1:0] SEL_X5   = 4'd5;
    localparam logic [SEL_W-1:0] SEL_X6   = 4'd6;
    localparam logic [SEL_W-1:0] SEL_ZERO = 4'd7;
    localparam logic [SEL_W-1:0] SEL_W0   = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        NEXT,
        FIN
    } state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/maj_operand_unit.sv
// Combinational gate evaluator: three operand muxes over {x, 0, w}, per-operand inversion, MAJ-3.
module maj_operand_unit
    import maj_net_pkg::*;
(
    input  logic [CFG_W-1:0]     desc,
    input  logic [N_IN-1:0]      x,
    input  logic [NUM_GATES-1:0] w,
    output logic                 y
);

    logic [7:0]       x_pool;
    logic [SEL_W-1:0] sel;
    logic [2:0]       opnd;

    // Select and optionally invert each operand, then take the majority
    always_comb begin
        // Padding x with a zero at index 7 makes code SEL_ZERO fall out of the x mux
        x_pool = {1'b0, x};
        sel    = '0;
        opnd   = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            sel     = desc[SEL0_OFS + k * SEL_W +: SEL_W];
            opnd[k] = (sel[3] ? w[sel[2:0]] : x_pool[sel[2:0]]) ^ desc[INV_OFS + k];
        end
        y = maj3(opnd[0], opnd[1], opnd[2]);
    end

endmodule

// File: rtl/maj_net_sequencer.sv
// Time-multiplexed MAJ-3 network evaluator: descriptor and w regfiles, counters, FSM, truth table.
module maj_net_sequencer
    import maj_net_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [CFG_W-1:0] cfg_data,
    input  logic             len_we,
    input  logic [3:0]       cfg_len,
    input  logic             start,
    input  logic             mode,
    input  logic [N_IN-1:0]  x_in,
    output logic             busy,
    output logic             done,
    output logic             out,
    output logic [N_PAT-1:0] tt,
    output logic             tt_valid
);

    state_e                 state_q, state_d;
    logic [CFG_W-1:0]       desc_q [NUM_GATES];
    logic [CFG_W-1:0]       desc_d [NUM_GATES];
    logic [3:0]             len_q, len_d;
    logic [NUM_GATES-1:0]   w_q, w_d;
    logic [2:0]             g_q, g_d;
    logic [N_IN-1:0]        pat_q, pat_d;
    logic                   mode_q, mode_d;
    logic                   out_q, out_d;
    logic [N_PAT-1:0]       tt_q, tt_d;
    logic                   tt_valid_q, tt_valid_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    logic [2:0]             last_g;
    logic                   w_last;
    logic                   gate_y;

    maj_operand_unit u_opnd (
        .desc (desc_q[g_q]),
        .x    (pat_q),
        .w    (w_q),
        .y    (gate_y)
    );

    // Next-state and datapath updates for the sequencing FSM
    always_comb begin
        state_d    = state_q;
        desc_d     = desc_q;
        len_d      = len_q;
        w_d        = w_q;
        g_d        = g_q;
        pat_d      = pat_q;
        mode_d     = mode_q;
        out_d      = out_q;
        tt_d       = tt_q;
        tt_valid_d = tt_valid_q;
        done_d     = 1'b0;
        busy_d     = busy_q;

        last_g = 3'(len_q - 4'd1);
        w_last = w_q[last_g];

        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    desc_d[cfg_addr] = cfg_data;
                end
                if (len_we && (cfg_len != 4'd0) && (cfg_len <= 4'd8)) begin
                    len_d = cfg_len;
                end
                if (start) begin
                    mode_d     = mode;
                    pat_d      = mode ? '0 : x_in;
                    g_d        = '0;
                    w_d        = '0;
                    tt_valid_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = EVAL;
                end
            end
            EVAL: begin
                w_d[g_q] = gate_y;
                if (g_q != last_g) begin
                    g_d = g_q + 3'd1;
                end else begin
                    state_d = mode_q ? NEXT : FIN;
                end
            end
            NEXT: begin
                tt_d[pat_q] = w_last;
                if (pat_q == 7'd127) begin
                    state_d = FIN;
                end else begin
                    pat_d   = pat_q + 7'd1;
                    g_d     = '0;
                    w_d     = '0;
                    state_d = EVAL;
                end
            end
            FIN: begin
                if (mode_q) begin
                    tt_valid_d = 1'b1;
                end else begin
                    out_d = w_last;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset to defaults
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            desc_q     <= '{default: '0};
            len_q      <= 4'd1;
            w_q        <= '0;
            g_q        <= '0;
            pat_q      <= '0;
            mode_q     <= 1'b0;
            out_q      <= 1'b0;
            tt_q       <= '0;
            tt_valid_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            desc_q     <= desc_d;
            len_q      <= len_d;
            w_q        <= w_d;
            g_q        <= g_d;
            pat_q      <= pat_d;
            mode_q     <= mode_d;
            out_q      <= out_d;
            tt_q       <= tt_d;
            tt_valid_q <= tt_valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign out      = out_q;
    assign tt       = tt_q;
    assign tt_valid = tt_valid_q;

endmodule

// File: tb/tb_maj_net_sequencer.sv
// Scoreboard bench for maj_net_sequencer: stimulus pushes expected results, a monitor checks on done.
module tb_maj_net_sequencer;
    import maj_net_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_we = 1'b0;
    logic [2:0]       cfg_addr = '0;
    logic [CFG_W-1:0] cfg_data = '0;
    logic             len_we = 1'b0;
    logic [3:0]       cfg_len = '0;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic [N_IN-1:0]  x_in = '0;
    logic             busy, done, out, tt_valid;
    logic [N_PAT-1:0] tt;

    maj_net_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .len_we   (len_we),
        .cfg_len  (cfg_len),
        .start    (start),
        .mode     (mode),
        .x_in     (x_in),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .tt       (tt),
        .tt_valid (tt_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             m;
        logic             o;
        logic [N_PAT-1:0] t;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t_acc = 0;
    int   done_cnt = 0;
    logic busy_prev = 1'b0;

    localparam logic [N_PAT-1:0] TT_REF = 128'hfeeaece8fee8e880fee8e880e8c8a880;
    localparam logic [N_PAT-1:0] TT_X0  = {32{4'hA}};

    function automatic logic [CFG_W-1:0] mk(input logic [2:0] inv, input logic [3:0] s2,
                                            input logic [3:0] s1, input logic [3:0] s0);
        return {inv, s2, s1, s0};
    endfunction

    function automatic void chk(input string name, input logic [N_PAT-1:0] act,
                                input logic [N_PAT-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: latency is measured from the first cycle busy is seen high
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && !busy_prev) t_acc = cyc;
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", 128'(cyc - t_acc), 128'(e.lat));
                    if (e.m) begin
                        chk("tt", tt, e.t);
                        chk("tt_valid_sweep", tt_valid, 1'b1);
                    end else begin
                        chk("out", out, e.o);
                        chk("tt_valid_single", tt_valid, 1'b0);
                    end
                end
            end
        end
        busy_prev = rst ? 1'b0 : busy;
    end

    task automatic wr_desc(input logic [2:0] a, input logic [CFG_W-1:0] d);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic wr_len(input logic [3:0] l);
        @(posedge clk); #1;
        len_we = 1'b1; cfg_len = l;
        @(posedge clk); #1;
        len_we = 1'b0;
    endtask

    task automatic issue(input logic m, input logic [6:0] x, input logic e_out,
                         input logic [N_PAT-1:0] e_tt, input int e_lat);
        exp_t e;
        e.m = m; e.o = e_out; e.t = e_tt; e.lat = e_lat;
        sb.push_back(e);
        @(posedge clk); #1;
        mode = m; x_in = x; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int budget);
        int k;
        k = 0;
        while (done_cnt == n0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt == n0) chk("done_timeout", 1'b0, 1'b1);
        repeat (3) @(posedge clk);
    endtask

    task automatic run(input logic m, input logic [6:0] x, input logic e_out,
                       input logic [N_PAT-1:0] e_tt, input int e_lat);
        int n0;
        n0 = done_cnt;
        issue(m, x, e_out, e_tt, e_lat);
        wait_done(n0, e_lat + 20);
    endtask

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_out", out, 1'b0);
        chk("rst_tt", tt, '0);
        chk("rst_tt_valid", tt_valid, 1'b0);

        // Default descriptors are identity on x0, len = 1
        run(1'b0, 7'h01, 1'b1, '0, 2);

        // Reference 6-gate network
        wr_desc(3'd0, mk(3'b000, SEL_X4, SEL_X3, SEL_X2));
        wr_desc(3'd1, mk(3'b000, SEL_X3, SEL_X2, SEL_X1));
        wr_desc(3'd2, mk(3'b000, SEL_X4, SEL_X2, SEL_X0));
        wr_desc(3'd3, mk(3'b000, SEL_W0, SEL_X6, SEL_X5));
        wr_desc(3'd4, mk(3'b000, 4'd11, 4'd10, SEL_X1));
        wr_desc(3'd5, mk(3'b000, 4'd12, 4'd9, SEL_X0));
        wr_len(4'd6);
        run(1'b1, 7'h00, 1'b0, TT_REF, 897);
        run(1'b0, 7'h07, 1'b1, '0, 7);
        run(1'b0, 7'h0C, 1'b0, '0, 7);
        run(1'b0, 7'h0D, 1'b1, '0, 7);

        // Start, descriptor write and length write during a sweep are all dropped
        n0 = done_cnt;
        issue(1'b1, 7'h00, 1'b0, TT_REF, 897);
        repeat (50) @(posedge clk);
        #1 start = 1'b1; mode = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        wr_desc(3'd5, mk(3'b000, SEL_ZERO, SEL_ZERO, SEL_ZERO));
        wr_len(4'd2);
        wait_done(n0, 917);
        repeat (10) @(posedge clk);
        chk("single_done_count", 128'(done_cnt - n0), 128'd1);
        run(1'b0, 7'h0D, 1'b1, '0, 7);

        // Illegal lengths leave len at 6
        wr_len(4'd0);
        wr_len(4'd9);
        run(1'b0, 7'h0D, 1'b1, '0, 7);

        // Inversion and constant operands
        wr_desc(3'd0, mk(3'b001, SEL_ZERO, SEL_ZERO, SEL_X0));
        wr_len(4'd1);
        run(1'b1, 7'h00, 1'b0, '0, 257);
        wr_desc(3'd0, mk(3'b010, SEL_ZERO, SEL_ZERO, SEL_X0));
        run(1'b1, 7'h00, 1'b0, TT_X0, 257);

        // Reset in the middle of a 6-gate sweep, around pattern 40
        wr_desc(3'd0, mk(3'b000, SEL_X4, SEL_X3, SEL_X2));
        wr_len(4'd6);
        issue(1'b1, 7'h00, 1'b0, TT_REF, 897);
        repeat (40 * 7 + 2) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_tt_valid", tt_valid, 1'b0);
        chk("midrst_tt", tt, '0);
        chk("midrst_done", done, 1'b0);
        run(1'b1, 7'h00, 1'b0, TT_X0, 257);
        run(1'b0, 7'h01, 1'b1, '0, 2);
        run(1'b0, 7'h7E, 1'b0, '0, 2);

        chk("scoreboard_empty", 128'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
